// File: rtl/cpu_datapath.sv
// cpu_datapath: NUM_REGS x DATA_W register file, registered-flag ALU and a
// three-state command sequencer (IDLE -> EXEC -> WB).
// Optional feature macro: CPU_DP_R0_ZERO_EN (R0 hardwired to zero).
//
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both high. o_cmd_ready depends only on state and reset,
// never on i_cmd_valid. The controller may change or drop a command freely
// while o_cmd_ready is low. There is no back-pressure on o_done: it is a
// single-cycle pulse.
module cpu_datapath #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_op,
  input  logic [AW-1:0]     i_cmd_src_a,
  input  logic [AW-1:0]     i_cmd_src_b,
  input  logic [AW-1:0]     i_cmd_dst,
  input  logic              i_cmd_cin,
  output logic              o_done,
  input  logic              i_ld_en,
  input  logic [AW-1:0]     i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_zr,
  output logic              o_ng,
  output logic              o_pa,
  output logic              o_co,
  output logic              o_of,
  output logic [1:0]        o_dbg_state
);

`ifdef CPU_DP_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;
  localparam logic [3:0] OP_PSA  = 4'd12;
  localparam logic [3:0] OP_PSB  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   wb_we;

  // Latched command
  logic [3:0]        op_q;
  logic [AW-1:0]     dst_q;
  logic              cin_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // Registered ALU result and flags
  logic [DATA_W-1:0] res_q;
  logic              zr_q, ng_q, pa_q, co_q, of_q;

  // ALU combinational outputs
  logic [DATA_W:0]   alu_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_co;
  logic              alu_of;

  // Read view of the register file (R0 forced to zero when hardwired)
  logic [DATA_W-1:0] regs_view [NUM_REGS];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and sequencer strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wb_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        wb_we   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_cmd_ready = (state_q == ST_IDLE) && !i_rst;
  assign o_done      = (state_q == ST_WB) && !i_rst;
  assign o_dbg_state = state_q;

  // Capture command fields and operand values (pre-edge register contents)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q  <= '0;
      dst_q <= '0;
      cin_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      op_q  <= i_cmd_op;
      dst_q <= i_cmd_dst;
      cin_q <= i_cmd_cin;
      a_q   <= regs_view[i_cmd_src_a];
      b_q   <= regs_view[i_cmd_src_b];
    end
  end

  // ALU: arithmetic is done DATA_W+1 wide so bit DATA_W is carry/borrow
  always_comb begin
    alu_ext = '0;
    alu_res = '0;
    alu_co  = 1'b0;
    alu_of  = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_ext = {1'b0, a_q} + {1'b0, b_q};
        alu_res = alu_ext[MSB:0];
        alu_co  = alu_ext[DATA_W];
        alu_of  = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_ADC: begin
        alu_ext = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, cin_q};
        alu_res = alu_ext[MSB:0];
        alu_co  = alu_ext[DATA_W];
        alu_of  = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_ext = {1'b0, a_q} - {1'b0, b_q};
        alu_res = alu_ext[MSB:0];
        alu_co  = alu_ext[DATA_W];
        alu_of  = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_SBB: begin
        alu_ext = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, cin_q};
        alu_res = alu_ext[MSB:0];
        alu_co  = alu_ext[DATA_W];
        alu_of  = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = {a_q[MSB-1:0], 1'b0};
        alu_co  = a_q[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[MSB:1]};
        alu_co  = a_q[0];
      end
      OP_INC: begin
        alu_ext = {1'b0, a_q} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = alu_ext[MSB:0];
        alu_co  = alu_ext[DATA_W];
        // +1 is positive: overflow only when a positive operand turns negative
        alu_of  = !a_q[MSB] && alu_res[MSB];
      end
      OP_DEC: begin
        alu_ext = {1'b0, a_q} - {{DATA_W{1'b0}}, 1'b1};
        alu_res = alu_ext[MSB:0];
        alu_co  = alu_ext[DATA_W];
        alu_of  = a_q[MSB] && !alu_res[MSB];
      end
      OP_PSA: alu_res = a_q;
      OP_PSB: alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  // Result and flag registers, updated only in EXEC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_q <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
      pa_q  <= 1'b0;
      co_q  <= 1'b0;
      of_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_q <= alu_res;
      zr_q  <= (alu_res == '0);
      ng_q  <= alu_res[MSB];
      pa_q  <= ~^alu_res;
      co_q  <= alu_co;
      of_q  <= alu_of;
    end
  end

  assign o_zr = zr_q;
  assign o_ng = ng_q;
  assign o_pa = pa_q;
  assign o_co = co_q;
  assign o_of = of_q;

  // Register file: writeback has priority over the load port on the same index
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (R0_ZERO && (g == 0)) begin : g_zero
      assign regs_view[g] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] r_q;
      // One register entry
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_q <= '0;
        end else if (wb_we && (dst_q == AW'(g))) begin
          r_q <= res_q;
        end else if (i_ld_en && (i_ld_addr == AW'(g))) begin
          r_q <= i_ld_data;
        end
      end
      assign regs_view[g] = r_q;
    end
  end

  assign o_rd_data = regs_view[i_rd_addr];

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed vectors for cpu_datapath (DATA_W=8, NUM_REGS=4).
// Expected {dst, result, flags} entries are queued at accept; a monitor pops
// one on every o_done, checks latency and flags, then reads back dst.
// Build with CPU_DP_R0_ZERO_EN defined to exercise the hardwired-R0 variant.
module tb_cpu_datapath;

  localparam int W  = 8;
  localparam int AW = 2;

`ifdef CPU_DP_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic          i_clk;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [3:0]    i_cmd_op;
  logic [AW-1:0] i_cmd_src_a;
  logic [AW-1:0] i_cmd_src_b;
  logic [AW-1:0] i_cmd_dst;
  logic          i_cmd_cin;
  logic          o_done;
  logic          i_ld_en;
  logic [AW-1:0] i_ld_addr;
  logic [W-1:0]  i_ld_data;
  logic [AW-1:0] i_rd_addr;
  logic [W-1:0]  o_rd_data;
  logic          o_zr, o_ng, o_pa, o_co, o_of;
  logic [1:0]    o_dbg_state;

  cpu_datapath #(.DATA_W(W), .NUM_REGS(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_src_a (i_cmd_src_a),
    .i_cmd_src_b (i_cmd_src_b),
    .i_cmd_dst   (i_cmd_dst),
    .i_cmd_cin   (i_cmd_cin),
    .o_done      (o_done),
    .i_ld_en     (i_ld_en),
    .i_ld_addr   (i_ld_addr),
    .i_ld_data   (i_ld_data),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_zr        (o_zr),
    .o_ng        (o_ng),
    .o_pa        (o_pa),
    .o_co        (o_co),
    .o_of        (o_of),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  // entry = {dst[14:13], readback[12:5], flags{zr,ng,pa,co,of}[4:0]}
  logic [14:0] exp_q[$];
  int          acc_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] d, input logic [W-1:0] v);
    if (R0_ZERO && (d == '0)) return '0;
    return v;
  endfunction

  // Monitor: every o_done must match the oldest queued command
  initial begin
    logic [14:0] e;
    int          a;
    forever begin
      @(negedge i_clk);
      if (o_done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: o_done=1 with no command pending (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("done_latency", cyc, a + 1);
          check("flags", {o_zr, o_ng, o_pa, o_co, o_of}, e[4:0]);
          i_rd_addr = e[14:13];
          @(negedge i_clk);
          #1;
          check("wb_result", o_rd_data, e[12:5]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [AW-1:0] addr, input logic [W-1:0] data);
    @(negedge i_clk);
    i_ld_en   = 1'b1;
    i_ld_addr = addr;
    i_ld_data = data;
    @(negedge i_clk);
    i_ld_en   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    @(negedge i_clk);
    i_rd_addr = addr;
    #1;
    check(name, o_rd_data, exp);
  endtask

  // Offers a command and returns just after the accepting edge; valid stays high.
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                       input logic [AW-1:0] d, input logic cin, input logic [W-1:0] res,
                       input logic [4:0] flg, input bit push, output int acc);
    int guard;
    @(negedge i_clk);
    i_cmd_op    = op;
    i_cmd_src_a = sa;
    i_cmd_src_b = sb;
    i_cmd_dst   = d;
    i_cmd_cin   = cin;
    i_cmd_valid = 1'b1;
    guard = 0;
    while (!o_cmd_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: o_cmd_ready=0 after 20 cycles, expected 1");
      i_cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      exp_q.push_back({d, exp_rd(d, res), flg});
      acc_q.push_back(acc);
    end
    @(posedge i_clk);
  endtask

  task automatic finish_cmd();
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  // Command with a load driven during its WB cycle
  task automatic issue_wb_load(input logic [3:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                               input logic [AW-1:0] d, input logic [W-1:0] res, input logic [4:0] flg,
                               input logic [AW-1:0] la, input logic [W-1:0] ld);
    int acc;
    issue(op, sa, sb, d, 1'b0, res, flg, 1'b1, acc);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    i_ld_en   = 1'b1;
    i_ld_addr = la;
    i_ld_data = ld;
    @(negedge i_clk);
    i_ld_en = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] sa;
    logic [AW-1:0] sb;
    logic [AW-1:0] d;
    logic          cin;
    logic [W-1:0]  res;
    logic [4:0]    flg;
  } vec_t;

  vec_t vt [7];

  initial begin
    int acc0, acc1, acc2;
    // R1=FF R2=01 R3=80, all results to R0
    vt[0] = '{4'd1,  2'd1, 2'd2, 2'd0, 1'b1, 8'h01, 5'b00010}; // ADC FF+01+1
    vt[1] = '{4'd10, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 5'b10110}; // INC FF
    vt[2] = '{4'd11, 2'd3, 2'd0, 2'd0, 1'b0, 8'h7F, 5'b00001}; // DEC 80
    vt[3] = '{4'd15, 2'd1, 2'd2, 2'd0, 1'b0, 8'h00, 5'b10100}; // reserved
    vt[4] = '{4'd3,  2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 5'b00010}; // SBB 01-FF-1
    vt[5] = '{4'd13, 2'd1, 2'd3, 2'd0, 1'b0, 8'h80, 5'b01000}; // PASS B
    vt[6] = '{4'd9,  2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 5'b10110}; // SHR 01

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = '0;
    i_cmd_src_a = '0;
    i_cmd_src_b = '0;
    i_cmd_dst   = '0;
    i_cmd_cin   = 1'b0;
    i_ld_en     = 1'b0;
    i_ld_addr   = '0;
    i_ld_data   = '0;
    i_rd_addr   = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("ready_in_reset", o_cmd_ready, 1'b0);
    i_rst = 1'b0;
    #1;
    check("ready_after_reset", o_cmd_ready, 1'b1);
    check("flags_after_reset", {o_zr, o_ng, o_pa, o_co, o_of}, 5'b00000);
    for (int r = 0; r < 4; r++) read_check("reg_after_reset", AW'(r), 8'h00);

    // ADD 7F+01 -> 80, signed overflow
    load(2'd1, 8'h7F);
    load(2'd2, 8'h01);
    issue(4'd0, 2'd1, 2'd2, 2'd3, 1'b0, 8'h80, 5'b01001, 1'b1, acc0);
    finish_cmd();

    // SUB 01-7F -> 82 with borrow, into R0
    issue(4'd2, 2'd2, 2'd1, 2'd0, 1'b0, 8'h82, 5'b01110, 1'b1, acc0);
    finish_cmd();

    // Back-to-back with valid held: ADD 7F+7F then SHL 81
    load(2'd2, 8'h81);
    issue(4'd0, 2'd1, 2'd1, 2'd3, 1'b0, 8'hFE, 5'b01001, 1'b1, acc1);
    issue(4'd8, 2'd2, 2'd0, 2'd1, 1'b0, 8'h02, 5'b00010, 1'b1, acc2);
    check("b2b_spacing", acc2 - acc1, 3);
    finish_cmd();

    // WB vs load on the same index: WB wins (AND FE&81 -> 80)
    issue_wb_load(4'd4, 2'd3, 2'd2, 2'd3, 8'h80, 5'b01000, 2'd3, 8'h55);
    read_check("collision_wb_wins", 2'd3, 8'h80);
    // Load to another index in parallel with WB (OR 02|81 -> 83)
    issue_wb_load(4'd5, 2'd1, 2'd2, 2'd3, 8'h83, 5'b01000, 2'd2, 8'h55);
    read_check("parallel_load", 2'd2, 8'h55);
    read_check("parallel_wb", 2'd3, 8'h83);

    // Reset during EXEC aborts: no o_done (monitor), flags cleared, dst stays 0
    issue(4'd0, 2'd1, 2'd2, 2'd1, 1'b0, 8'h57, 5'b00000, 1'b0, acc0);
    @(negedge i_clk);
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("flags_after_abort", {o_zr, o_ng, o_pa, o_co, o_of}, 5'b00000);
    read_check("dst_after_abort", 2'd1, 8'h00);

    // Opcode table
    load(2'd1, 8'hFF);
    load(2'd2, 8'h01);
    load(2'd3, 8'h80);
    for (int i = 0; i < 7; i++) begin
      issue(vt[i].op, vt[i].sa, vt[i].sb, vt[i].d, vt[i].cin, vt[i].res, vt[i].flg, 1'b1, acc0);
      finish_cmd();
    end

    // Flags hold between commands (last command was SHR 01)
    repeat (3) @(negedge i_clk);
    check("flags_hold", {o_zr, o_ng, o_pa, o_co, o_of}, 5'b10110);

    // Direct load to R0
    load(2'd0, 8'h55);
    read_check("r0_load", 2'd0, R0_ZERO ? 8'h00 : 8'h55);

    repeat (4) @(negedge i_clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
